// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton decoder and related board-input logic.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_DOWN,
        HELD,
        DEB_UP
    } btn_state_e;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, with a caller-chosen reset level.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= rst_val;
            s2_q <= rst_val;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_press_decoder.sv
// Debounces a raw pushbutton into a held level plus press, release and long-press pulses.
module button_press_decoder
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(20),
    parameter int LONG_CYCLES     = ms_to_cycles(1000),
    parameter bit BTN_ACTIVE      = 1'b1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iBTN,
    output logic       oPRESSED,
    output logic       oPRESS,
    output logic       oRELEASE,
    output logic       oLONG,
    output logic [7:0] oCOUNT
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic btn_s;
    logic p;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk    (iCLK),
        .rst    (iRST),
        .rst_val(~BTN_ACTIVE),
        .d      (iBTN),
        .q      (btn_s)
    );

    assign p = (btn_s == BTN_ACTIVE);

    btn_state_e    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_flag_q, long_flag_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic [7:0]    count_q, count_d;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        long_cnt_d  = long_cnt_q;
        long_flag_d = long_flag_q;
        pressed_d   = pressed_q;
        count_d     = count_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d   = DEB_DOWN;
                    deb_cnt_d = '0;
                end
            end
            DEB_DOWN: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    pressed_d   = 1'b1;
                    count_d     = count_q + 8'd1;
                    long_cnt_d  = '0;
                    long_flag_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!p) begin
                    state_d   = DEB_UP;
                    deb_cnt_d = '0;
                end else if (!long_flag_q) begin
                    // Saturate at the terminal value; the flag blocks further counting.
                    if (long_cnt_q == LONG_LAST) begin
                        long_d      = 1'b1;
                        long_flag_d = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + LW'(1);
                    end
                end
            end
            DEB_UP: begin
                // Release bounce returns to HELD with the long-press progress intact.
                if (p) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            long_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_flag_q <= long_flag_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    assign oPRESSED = pressed_q;
    assign oPRESS   = press_q;
    assign oRELEASE = release_q;
    assign oLONG    = long_q;
    assign oCOUNT   = count_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed and randomized checks of the button decoder against a run-length reference model.
module tb_button_press_decoder;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iBTN = 1'b0;
    logic       oPRESSED, oPRESS, oRELEASE, oLONG;
    logic [7:0] oCOUNT;

    int checks = 0;
    int errors = 0;

    button_press_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .BTN_ACTIVE     (1'b1)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iBTN    (iBTN),
        .oPRESSED(oPRESSED),
        .oPRESS  (oPRESS),
        .oRELEASE(oRELEASE),
        .oLONG   (oLONG),
        .oCOUNT  (oCOUNT)
    );

    always #10 iCLK = ~iCLK;

    // Reference model: an accepted level flips after DEB+1 consecutive
    // disagreeing samples; a long press is the LONG-th steady held sample.
    logic       m_d1, m_d2;
    logic       m_held, m_fired;
    int         m_run, m_long_k;
    logic       m_press, m_rel, m_long;
    logic [7:0] m_count;

    int n_press = 0, n_rel = 0, n_long = 0;

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_held = 0; m_fired = 0;
        m_run = 0; m_long_k = 0;
        m_press = 0; m_rel = 0; m_long = 0; m_count = 0;
    endtask

    task automatic model_step();
        logic p;
        p = m_d2;
        m_press = 0; m_rel = 0; m_long = 0;
        if (p != m_held) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_held = p;
                m_run  = 0;
                if (p) begin
                    m_press = 1; m_count++; m_long_k = 0; m_fired = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end else begin
            if (m_held && m_run == 0 && !m_fired) begin
                m_long_k++;
                if (m_long_k == LONG) begin
                    m_long = 1; m_fired = 1;
                end
            end
            m_run = 0;
        end
        m_d2 = m_d1;
        m_d1 = iBTN;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("pressed", int'(oPRESSED), int'(m_held));
        chk("press",   int'(oPRESS),   int'(m_press));
        chk("release", int'(oRELEASE), int'(m_rel));
        chk("long",    int'(oLONG),    int'(m_long));
        chk("count",   int'(oCOUNT),   int'(m_count));
    endtask

    task automatic tick();
        @(posedge iCLK);
        if (!iRST) model_step();
        @(negedge iCLK);
        check_outputs();
        n_press += int'(oPRESS);
        n_rel   += int'(oRELEASE);
        n_long  += int'(oLONG);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int e_press, e_rel, e_long, p0, r0, l0, k;
        logic [7:0] c0;

        model_reset();
        ticks(3);
        iRST = 1'b0;

        // 1: idle, then asynchronous reset with everything already zero
        ticks(10);
        #3 iRST = 1'b1;
        #1 model_reset();
        check_outputs();
        ticks(2);
        iRST = 1'b0;
        ticks(2);

        // 2: clean press and release latency
        iBTN = 1; e_press = 0;
        for (int i = 1; i <= 12; i++) begin tick(); if (oPRESS) e_press = i; end
        chk("press_edge", e_press, DEB + 3);
        chk("count_after_press", int'(oCOUNT), 1);
        chk("pressed_level", int'(oPRESSED), 1);
        iBTN = 0; e_rel = 0;
        for (int i = 1; i <= 12; i++) begin tick(); if (oRELEASE) e_rel = i; end
        chk("release_edge", e_rel, DEB + 3);
        chk("released_level", int'(oPRESSED), 0);

        // 3: short glitch rejected, then bouncy press accepted once
        p0 = n_press;
        iBTN = 1; ticks(3); iBTN = 0; ticks(10);
        chk("glitch_no_press", n_press - p0, 0);
        chk("glitch_count", int'(oCOUNT), 1);
        iBTN = 1; tick(); iBTN = 0; tick(); iBTN = 1; tick(); iBTN = 0; tick();
        iBTN = 1; ticks(15);
        chk("bounce_one_press", n_press - p0, 1);
        iBTN = 0; ticks(12);

        // 4: long press timing, plain and with a release bounce
        for (int pass = 0; pass < 2; pass++) begin
            iBTN = 1; k = 0;
            while (!oPRESS && k < 20) begin tick(); k++; end
            chk("long_press_seen", int'(oPRESS), 1);
            l0 = n_long; r0 = n_rel; e_long = 0;
            for (int i = 1; i <= 35; i++) begin
                if (pass == 1 && i == 6) iBTN = 0;
                if (pass == 1 && i == 8) iBTN = 1;
                tick();
                if (oLONG) e_long = i;
            end
            chk("long_single", n_long - l0, 1);
            chk("long_delay", e_long, (pass == 1) ? LONG + 3 : LONG);
            chk("long_no_release", n_rel - r0, 0);
            iBTN = 0; ticks(12);
        end

        // random bouncing, checked cycle by cycle against the model
        for (int i = 0; i < 120; i++) begin
            iBTN = 1'($urandom_range(0, 1));
            ticks($urandom_range(1, 9));
        end
        iBTN = 0; ticks(12);

        // 5: 256 clean presses wrap the counter
        p0 = n_press; r0 = n_rel; c0 = oCOUNT;
        for (int i = 0; i < 256; i++) begin
            iBTN = 1; ticks(8);
            iBTN = 0; ticks(8);
        end
        chk("wrap_presses", n_press - p0, 256);
        chk("wrap_releases", n_rel - r0, 256);
        chk("wrap_count", int'(oCOUNT), int'(c0));

        // 6: reset while held, then the still-held button is a fresh press
        iBTN = 1; ticks(12);
        chk("held_before_reset", int'(oPRESSED), 1);
        r0 = n_rel;
        #3 iRST = 1'b1;
        #1 model_reset();
        check_outputs();
        ticks(2);
        iRST = 1'b0;
        e_press = 0;
        for (int i = 1; i <= 12; i++) begin tick(); if (oPRESS) e_press = i; end
        chk("reset_no_release", n_rel - r0, 0);
        chk("repress_edge", e_press, DEB + 3);
        chk("repress_count", int'(oCOUNT), 1);
        iBTN = 0; ticks(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
